// File: rtl/memory_access_stage.sv
// MEM stage with data-memory handshake, load lane formatting and the MEM/WB register.
// Results reach the W outputs 1 cycle after the completing MEM cycle; StallM holds upstream while dmem_ready is low.
module memory_access_stage #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        RegWriteW_reg,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // Last WAIT-cycle count value before the access is declared dead.
  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        is_load, memop, sz_byte, sz_half, sz_word;
  logic        misaligned, access, timeout, waiting, bubble;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic [3:0]  strb;
  logic [31:0] wdat;

  logic        rw_q, rw_d;
  logic [1:0]  rs_q, rs_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rdat_q, rdat_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc4_q, pc4_d;

  assign lane       = ALUResultM[1:0];
  assign is_load    = (ResultSrcM == 2'b01);
  assign memop      = is_load | MemWriteM;
  assign sz_byte    = (funct3M[1:0] == 2'b00);
  assign sz_half    = (funct3M[1:0] == 2'b01);
  assign sz_word    = ~sz_byte & ~sz_half;
  assign misaligned = (sz_half & lane[0]) | (sz_word & (lane != 2'b00));
  assign access     = memop & ~misaligned;
  assign timeout    = (state_q == S_WAIT) & (cnt_q == WaitLast);
  assign waiting    = access & ~dmem_ready & ~timeout;
  assign bubble     = waiting | (memop & misaligned) | timeout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (access & ~dmem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timeout | dmem_ready | ~access) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Store lane replication; anything that is not byte or half is a full word.
  always_comb begin
    strb = 4'b0000;
    wdat = WriteDataM;
    if (sz_byte) begin
      strb = 4'b0001 << lane;
      wdat = {4{WriteDataM[7:0]}};
    end else if (sz_half) begin
      strb = 4'b0011 << lane;
      wdat = {2{WriteDataM[15:0]}};
    end else begin
      strb = 4'hF;
    end
    if (!MemWriteM) strb = 4'b0000;
  end

  always_comb begin
    case (lane)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3M)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'b0, ld_byte};
      3'b101:  ld_fmt = {16'b0, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  // Gating with rst drops the request and status outputs the moment reset asserts.
  assign dmem_req   = rst & access & ~timeout;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_wdata = wdat;
  assign dmem_wstrb = strb;
  assign StallM     = rst & waiting;
  assign MisalignM  = rst & memop & misaligned;
  assign BusErrM    = rst & timeout;

  always_comb begin
    rw_d   = RegWriteM & ~bubble;
    rs_d   = ResultSrcM;
    alu_d  = ALUResultM;
    rdat_d = is_load ? ld_fmt : 32'd0;
    rd_d   = RdM;
    pc4_d  = PCPlus4M;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      rs_q    <= '0;
      alu_q   <= '0;
      rdat_q  <= '0;
      rd_q    <= '0;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      rs_q    <= rs_d;
      alu_q   <= alu_d;
      rdat_q  <= rdat_d;
      rd_q    <= rd_d;
      pc4_q   <= pc4_d;
    end
  end

  assign RegWriteW_reg = rw_q;
  assign ResultSrcW    = rs_q;
  assign ALUResultW    = alu_q;
  assign ReadDataW     = rdat_q;
  assign RdW           = rd_q;
  assign PCPlus4W      = pc4_q;

endmodule
